// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer and the fetch stage:
// PC width, sequencer state encoding and per-program base addresses.
package seq_pkg;

    localparam int unsigned PC_W      = 11;
    localparam int unsigned NUM_BASES = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] PROG_BASE [NUM_BASES] = '{11'd0, 11'd256, 11'd512};

    // Unknown program indices map to address 0 rather than an X.
    function automatic logic [PC_W-1:0] prog_base(input int unsigned idx);
        case (idx)
            0:       return PROG_BASE[0];
            1:       return PROG_BASE[1];
            2:       return PROG_BASE[2];
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// RUN-cycle counter with synchronous clear, enable and saturation at MAX_CYC.
// hit_c flags that the current enabled cycle is the one that reaches MAX_CYC.
module cycle_counter #(
    parameter int unsigned CYC_W   = 16,
    parameter int unsigned MAX_CYC = 32'hFFFF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CYC_W-1:0] count_o,
    output logic             hit_c
);

    localparam logic [CYC_W-1:0] LIMIT = CYC_W'(MAX_CYC);
    localparam logic [CYC_W-1:0] LAST  = CYC_W'(MAX_CYC - 1);

    logic [CYC_W-1:0] count_q;
    logic [CYC_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + CYC_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign hit_c   = en_i && (count_q >= LAST);

endmodule

// File: rtl/prog_sequencer.sv
// Program-series sequencer: loads each program's base PC into fetch, releases
// the PC hold until halt or watchdog, then reports completion via Req/Done.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned NUM_PROGS = 3,
    parameter int unsigned CYC_W     = 16,
    parameter int unsigned MAX_CYC   = 32'hFFFF,
    localparam int unsigned PN_W     = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req,
    input  logic             Halt_In,
    output logic             Start,
    output logic             Load_Pc,
    output logic [PC_W-1:0]  Base_Addr,
    output logic [PN_W-1:0]  Prog_Num,
    output logic             Busy,
    output logic             Done,
    output logic             Timeout,
    output logic [CYC_W-1:0] Cycle_Count
);

    localparam logic [PN_W-1:0] LAST_PROG = PN_W'(NUM_PROGS - 1);

    state_t          state_q, state_d;
    logic [PN_W-1:0] prog_num_q, prog_num_d;
    logic            start_q, start_d;
    logic            load_pc_q, load_pc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            timeout_q, timeout_d;
    logic            cnt_clr;
    logic            cnt_en;
    logic            cnt_hit;

    cycle_counter #(
        .CYC_W   (CYC_W),
        .MAX_CYC (MAX_CYC)
    ) u_cycle_counter (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (Cycle_Count),
        .hit_c   (cnt_hit)
    );

    // Next state; registered outputs are decoded from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d    = state_q;
        prog_num_d = prog_num_q;
        timeout_d  = timeout_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req) begin
                    state_d = LOAD;
                    cnt_clr = 1'b1;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (Halt_In) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (cnt_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (!Req) begin
                    state_d    = IDLE;
                    timeout_d  = 1'b0;
                    prog_num_d = (prog_num_q == LAST_PROG) ? '0 : prog_num_q + PN_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                timeout_d = 1'b0;
            end
        endcase

        start_d   = (state_d != RUN);
        load_pc_d = (state_d == LOAD);
        busy_d    = (state_d == LOAD) || (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            prog_num_q <= '0;
            start_q    <= 1'b1;
            load_pc_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_num_q <= prog_num_d;
            start_q    <= start_d;
            load_pc_q  <= load_pc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign Start     = start_q;
    assign Load_Pc   = load_pc_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Timeout   = timeout_q;
    assign Prog_Num  = prog_num_q;
    assign Base_Addr = prog_base(32'(prog_num_q));

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized bench for prog_sequencer against a transaction-level model of
// program index, base address, run length and watchdog outcome.
module tb_prog_sequencer;

    localparam int unsigned NPROG = 3;
    localparam int unsigned CYCW  = 16;
    localparam int unsigned MAXC  = 20;

    logic        Clk;
    logic        Reset;
    logic        Req;
    logic        Halt_In;
    logic        Start;
    logic        Load_Pc;
    logic [10:0] Base_Addr;
    logic [1:0]  Prog_Num;
    logic        Busy;
    logic        Done;
    logic        Timeout;
    logic [15:0] Cycle_Count;

    int n_checks;
    int n_errs;
    int exp_prog;
    int last_count;

    prog_sequencer #(
        .NUM_PROGS (NPROG),
        .CYC_W     (CYCW),
        .MAX_CYC   (MAXC)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req         (Req),
        .Halt_In     (Halt_In),
        .Start       (Start),
        .Load_Pc     (Load_Pc),
        .Base_Addr   (Base_Addr),
        .Prog_Num    (Prog_Num),
        .Busy        (Busy),
        .Done        (Done),
        .Timeout     (Timeout),
        .Cycle_Count (Cycle_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int exp_base(input int p);
        return p * 256;
    endfunction

    // Flags packed as {Start, Busy, Load_Pc, Done}.
    function automatic logic [31:0] flags();
        return 32'({Start, Busy, Load_Pc, Done});
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Req     = 1'b0;
            Halt_In = 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
            check_val("idle_flags", flags(), 32'b1000);
            check_val("idle_cnt", 32'(Cycle_Count), 32'(last_count));
            check_val("idle_prog", 32'(Prog_Num), 32'(exp_prog));
            check_val("idle_base", 32'(Base_Addr), 32'(exp_base(exp_prog)));
        end
    endtask

    // halt_at: RUN cycle (1-based) on which Halt_In is raised; 0 = never.
    task automatic run_prog(input int halt_at);
        int  end_k;
        bit  exp_to;
        int  hold;
        exp_to = !(halt_at >= 1 && halt_at <= int'(MAXC));
        end_k  = exp_to ? int'(MAXC) : halt_at;

        @(negedge Clk);
        Req     = 1'b1;
        Halt_In = 1'($urandom_range(0, 1));
        @(posedge Clk);
        #1;
        check_val("load_flags", flags(), 32'b1110);
        check_val("load_base", 32'(Base_Addr), 32'(exp_base(exp_prog)));
        check_val("load_cnt", 32'(Cycle_Count), 32'd0);

        @(negedge Clk);
        Req     = 1'($urandom_range(0, 1));
        Halt_In = 1'($urandom_range(0, 1));
        @(posedge Clk);
        #1;
        check_val("run_entry", flags(), 32'b0100);
        check_val("run_entry_cnt", 32'(Cycle_Count), 32'd0);

        for (int k = 1; k <= end_k; k++) begin
            @(negedge Clk);
            Halt_In = (k == halt_at);
            Req     = 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
            if (k < end_k) begin
                check_val("run_flags", flags(), 32'b0100);
                check_val("run_cnt", 32'(Cycle_Count), 32'(k));
            end
        end
        check_val("done_flags", flags(), 32'b1001);
        check_val("done_cnt", 32'(Cycle_Count), 32'(end_k));
        check_val("done_timeout", 32'(Timeout), 32'(exp_to));

        hold = int'($urandom_range(0, 3));
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            Req     = 1'b1;
            Halt_In = 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
            check_val("hold_flags", flags(), 32'b1001);
            check_val("hold_cnt", 32'(Cycle_Count), 32'(end_k));
            check_val("hold_timeout", 32'(Timeout), 32'(exp_to));
        end

        @(negedge Clk);
        Req     = 1'b0;
        Halt_In = 1'($urandom_range(0, 1));
        @(posedge Clk);
        #1;
        exp_prog   = (exp_prog + 1) % int'(NPROG);
        last_count = end_k;
        check_val("rel_flags", flags(), 32'b1000);
        check_val("rel_timeout", 32'(Timeout), 32'd0);
        check_val("rel_prog", 32'(Prog_Num), 32'(exp_prog));
        check_val("rel_base", 32'(Base_Addr), 32'(exp_base(exp_prog)));
        check_val("rel_cnt", 32'(Cycle_Count), 32'(end_k));
    endtask

    task automatic reset_mid_run();
        @(negedge Clk);
        Req     = 1'b1;
        Halt_In = 1'b0;
        @(posedge Clk);
        #1;
        check_val("mr_load", flags(), 32'b1110);
        @(posedge Clk);
        #1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge Clk);
            Halt_In = 1'b0;
            Req     = 1'($urandom_range(0, 1));
            @(posedge Clk);
            #1;
        end
        check_val("mr_cnt7", 32'(Cycle_Count), 32'd7);
        #2;
        Reset = 1'b1;
        #1;
        check_val("mr_rst_flags", flags(), 32'b1000);
        check_val("mr_rst_prog", 32'(Prog_Num), 32'd0);
        check_val("mr_rst_cnt", 32'(Cycle_Count), 32'd0);
        check_val("mr_rst_to", 32'(Timeout), 32'd0);
        check_val("mr_rst_base", 32'(Base_Addr), 32'd0);
        @(negedge Clk);
        Reset      = 1'b0;
        Req        = 1'b0;
        exp_prog   = 0;
        last_count = 0;
        idle_cycles(3);
    endtask

    initial begin
        n_checks   = 0;
        n_errs     = 0;
        exp_prog   = 0;
        last_count = 0;
        Req        = 1'b0;
        Halt_In    = 1'b0;
        Reset      = 1'b1;
        #1;
        check_val("reset_flags", flags(), 32'b1000);
        check_val("reset_prog", 32'(Prog_Num), 32'd0);
        check_val("reset_cnt", 32'(Cycle_Count), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        idle_cycles(5);
        run_prog(10);
        idle_cycles(2);
        run_prog(int'($urandom_range(1, MAXC)));
        run_prog(int'($urandom_range(1, MAXC)));
        run_prog(int'(MAXC));
        run_prog(0);
        run_prog(int'(MAXC) + 1);
        run_prog(1);
        run_prog(int'(MAXC) - 1);
        for (int i = 0; i < 12; i++) begin
            run_prog(int'($urandom_range(0, MAXC + 4)));
            idle_cycles(int'($urandom_range(0, 3)));
        end
        if (exp_prog == 0) run_prog(5);
        reset_mid_run();
        run_prog(int'($urandom_range(1, MAXC)));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Upstream control stage for the instruction-fetch program counter.
- Runs the multi-program series one program at a time. Drives the fetch stage's Start hold input plus a one-cycle PC load of the selected program's base address, then waits for the program's halt.
- Counts execution cycles per program, enforces a watchdog, and reports completion to the host or bench with a level handshake.

Parameters:
- NUM_PROGS, 3, number of programs in the series; Prog_Num wraps after NUM_PROGS-1.
- PC_W, 11, program counter width; matches the fetch stage.
- CYC_W, 16, cycle counter width.
- MAX_CYC, 16'hFFFF, watchdog limit in RUN cycles; must be at least 1.

Ports:
- Clk  in  1  single clock; all state changes on posedge.
- Reset  in  1  asynchronous, active-high; forces the reset state immediately.
- Req  in  1  level request from host/bench to run the next program.
- Halt_In  in  1  decoded halt instruction from control; meaningful only in RUN.
- Start  out  1  to fetch Start; 1 holds the PC, 0 lets it advance.
- Load_Pc  out  1  one-cycle pulse; the PC loads Base_Addr on that edge.
- Base_Addr  out  PC_W  start address of the program selected by Prog_Num.
- Prog_Num  out  $clog2(NUM_PROGS)  index of the current or next program.
- Busy  out  1  high in LOAD and RUN.
- Done  out  1  completion flag, held until the handshake releases it.
- Timeout  out  1  valid with Done; 1 = watchdog ended the run, not a halt.
- Cycle_Count  out  CYC_W  RUN cycles of the current/last program; frozen in DONE.

Behaviour:
- Reset (async) values:
  - state=IDLE, Start=1, Load_Pc=0, Busy=0, Done=0, Timeout=0.
  - Prog_Num=0, Cycle_Count=0; Base_Addr = table entry 0 (combinational from Prog_Num).
- IDLE:
  - Outputs: Start=1, Busy=0.
  - Transition: Req==1 sampled at a posedge -> LOAD. Cycle_Count clears to 0 on that same edge.
- LOAD (exactly 1 cycle):
  - Outputs: Load_Pc=1, Start=1, Busy=1.
  - Transition: next edge -> RUN.
- RUN:
  - Outputs: Start=0, Busy=1.
  - Cycle_Count increments every cycle spent in RUN.
  - Halt_In==1 -> DONE with Timeout=0. The halt cycle is counted, so the first RUN cycle with Halt_In gives Cycle_Count=1.
  - Count reaching MAX_CYC with no halt -> DONE with Timeout=1. Count stops at MAX_CYC.
  - Halt_In and count==MAX_CYC-1 on the same edge: the halt wins, Timeout=0.
  - Req is ignored in RUN.
- DONE:
  - Outputs: Start=1, Done=1, Busy=0; Cycle_Count and Timeout hold.
  - Transition: Req==0 -> IDLE. On that edge Done and Timeout clear and Prog_Num increments, wrapping NUM_PROGS-1 -> 0.
  - If Req stays high, remain in DONE; there is no auto-restart.
- Halt_In outside RUN is ignored.
- Latency: Req high to first PC advance = 2 edges (IDLE->LOAD, LOAD->RUN).
- Reset mid-RUN: immediate return to IDLE. Prog_Num returns to 0, the run is lost, and no Done is produced.
- Illegal state encodings recover to IDLE.
- Base_Addr is a pure function of Prog_Num via the package table; no registered latency.

Decomposition:
- Shared package (seq_pkg) holds:
  - state enum: IDLE, LOAD, RUN, DONE;
  - PROG_BASE table: prog 0 = 11'd0, prog 1 = 11'd256, prog 2 = 11'd512;
  - the PC_W constant, shared with the fetch stage.
- One sub-module, cycle_counter: clear/enable/saturate at MAX_CYC, with a reached flag. The FSM stays in prog_sequencer.

Test Plan:
1. Reset, then idle 5 cycles -> Start=1, Busy=0, Done=0, Prog_Num=0, Load_Pc never pulses.
2. Req=1; Halt_In pulsed on the 10th RUN cycle -> Load_Pc pulses once with Base_Addr=0; Done=1, Timeout=0, Cycle_Count=10; Req=0 -> Prog_Num=1, Base_Addr=256.
3. Run three programs back to back -> Base_Addr 0, 256, 512 at the respective Load_Pc pulses; after the third handshake Prog_Num wraps to 0.
4. MAX_CYC=20, no Halt_In -> Done=1, Timeout=1, Cycle_Count=20, Start returns to 1.
5. Halt_In asserted in IDLE and DONE, Req toggled during RUN -> no state change, Cycle_Count unaffected.
6. Reset asserted asynchronously mid-clock during RUN at count 7 -> outputs take reset values before the next posedge (Start=1, Busy=0, Prog_Num=0); Done never asserts.
